// File: rtl/byte_ram_hs.sv
// byte_ram_hs: byte-addressable big-endian synchronous RAM behind a
// four-phase Enable/MOC handshake. Supports byte, halfword, word and
// two-beat doubleword accesses, programmable wait states and optional
// alignment rejection.
module byte_ram_hs #(
   parameter int ADDR_WIDTH   = 8,
   parameter int WAIT_CYCLES  = 1,
   parameter int STRICT_ALIGN = 0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Enable,
   input  logic                  ReadWrite,
   input  logic [1:0]            Mode,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic [31:0]           DataIn,
   output logic [31:0]           DataOut,
   output logic                  MOC,
   output logic                  Beat,
   output logic                  Err
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   // Last value of the wait counter before moving on to ACCESS.
   localparam logic [3:0] LP_WLAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   localparam logic [1:0] M_BYTE = 2'b00;
   localparam logic [1:0] M_HALF = 2'b01;
   localparam logic [1:0] M_DW   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_DONE,
      S_GAP
   } state_t;

   state_t                r_state;
   logic                  r_rw;
   logic [1:0]            r_mode;
   logic [ADDR_WIDTH-1:0] r_addr;   // base address of the current beat
   logic [3:0]            r_cnt;
   logic                  r_bad;    // latched misalignment of the request
   logic [31:0]           r_dout;
   logic                  r_moc;
   logic                  r_beat;
   logic                  r_err;
   logic [7:0]            r_mem [DEPTH];

   logic [ADDR_WIDTH-1:0] w_a0, w_a1, w_a2, w_a3;
   logic                  w_misalign;
   logic                  w_wr_en;
   logic [31:0]           w_rd_data;

   // Byte addresses of the beat; the narrow adds wrap modulo DEPTH.
   assign w_a0    = r_addr;
   assign w_a1    = r_addr + ADDR_WIDTH'(1);
   assign w_a2    = r_addr + ADDR_WIDTH'(2);
   assign w_a3    = r_addr + ADDR_WIDTH'(3);
   assign w_wr_en = (r_state == S_ACCESS) && !r_rw && !r_bad;

   assign DataOut = r_dout;
   assign MOC     = r_moc;
   assign Beat    = r_beat;
   assign Err     = r_err;

   // Alignment check on the incoming request (only when strict).
   always_comb begin
      w_misalign = 1'b0;
      if (STRICT_ALIGN != 0) begin
         case (Mode)
            M_HALF:  w_misalign = Address[0];
            2'b10:   w_misalign = |Address[1:0];
            M_DW:    w_misalign = |Address[2:0];
            default: w_misalign = 1'b0;
         endcase
      end
   end

   // Big-endian read assembly, right-aligned and zero-extended.
   always_comb begin
      w_rd_data = 32'd0;
      case (r_mode)
         M_BYTE:  w_rd_data = {24'd0, r_mem[w_a0]};
         M_HALF:  w_rd_data = {16'd0, r_mem[w_a0], r_mem[w_a1]};
         default: w_rd_data = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
      endcase
   end

   // Memory array write at the access edge; contents survive reset.
   always_ff @(posedge Clk) begin
      if (!Reset && w_wr_en) begin
         case (r_mode)
            M_BYTE: r_mem[w_a0] <= DataIn[7:0];
            M_HALF: begin
               r_mem[w_a0] <= DataIn[15:8];
               r_mem[w_a1] <= DataIn[7:0];
            end
            default: begin
               r_mem[w_a0] <= DataIn[31:24];
               r_mem[w_a1] <= DataIn[23:16];
               r_mem[w_a2] <= DataIn[15:8];
               r_mem[w_a3] <= DataIn[7:0];
            end
         endcase
      end
   end

   // Handshake FSM with registered DataOut/MOC/Beat/Err.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_rw    <= 1'b0;
         r_mode  <= 2'b00;
         r_addr  <= '0;
         r_cnt   <= 4'd0;
         r_bad   <= 1'b0;
         r_dout  <= 32'd0;
         r_moc   <= 1'b0;
         r_beat  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Enable) begin
                  r_rw    <= ReadWrite;
                  r_mode  <= Mode;
                  r_addr  <= Address;
                  r_bad   <= w_misalign;
                  r_beat  <= 1'b0;
                  r_cnt   <= 4'd0;
                  r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
               end
            end
            S_WAIT: begin
               if (r_cnt == LP_WLAST) begin
                  r_cnt   <= 4'd0;
                  r_state <= S_ACCESS;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_ACCESS: begin
               r_moc   <= 1'b1;
               r_err   <= r_bad;
               if (!r_bad && r_rw)
                  r_dout <= w_rd_data;
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (!Enable) begin
                  r_moc <= 1'b0;
                  r_err <= 1'b0;
                  // A rejected doubleword never gets a second beat.
                  if (r_mode == M_DW && !r_beat && !r_bad) begin
                     r_beat  <= 1'b1;
                     r_addr  <= r_addr + ADDR_WIDTH'(4);
                     r_state <= S_GAP;
                  end else begin
                     r_beat  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (Enable) begin
                  r_cnt   <= 4'd0;
                  r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_ram_hs.sv
// tb_byte_ram_hs: directed table-driven bench for byte_ram_hs using three
// instances: u0 (1 wait, lax), u1 (3 waits, strict), u2 (0 waits, lax).
module tb_byte_ram_hs;

   logic        clk;
   logic        rst  [3];
   logic        en   [3];
   logic        rw   [3];
   logic [1:0]  md   [3];
   logic [7:0]  ad   [3];
   logic [31:0] din  [3];
   logic [31:0] dout [3];
   logic        moc  [3];
   logic        bt   [3];
   logic        er   [3];

   int n_pass = 0;
   int n_tot  = 0;

   byte_ram_hs #(.ADDR_WIDTH(8), .WAIT_CYCLES(1), .STRICT_ALIGN(0)) u0 (
      .Clk(clk), .Reset(rst[0]), .Enable(en[0]), .ReadWrite(rw[0]), .Mode(md[0]),
      .Address(ad[0]), .DataIn(din[0]), .DataOut(dout[0]), .MOC(moc[0]),
      .Beat(bt[0]), .Err(er[0]));
   byte_ram_hs #(.ADDR_WIDTH(8), .WAIT_CYCLES(3), .STRICT_ALIGN(1)) u1 (
      .Clk(clk), .Reset(rst[1]), .Enable(en[1]), .ReadWrite(rw[1]), .Mode(md[1]),
      .Address(ad[1]), .DataIn(din[1]), .DataOut(dout[1]), .MOC(moc[1]),
      .Beat(bt[1]), .Err(er[1]));
   byte_ram_hs #(.ADDR_WIDTH(8), .WAIT_CYCLES(0), .STRICT_ALIGN(0)) u2 (
      .Clk(clk), .Reset(rst[2]), .Enable(en[2]), .ReadWrite(rw[2]), .Mode(md[2]),
      .Address(ad[2]), .DataIn(din[2]), .DataOut(dout[2]), .MOC(moc[2]),
      .Beat(bt[2]), .Err(er[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          d;
      bit          rdwr;
      logic [1:0]  mode;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          lat;
      bit          cd;
      logic [31:0] xdout;
      logic        xerr;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   // One beat: raise Enable, wait (bounded) for MOC, drop Enable, check MOC falls.
   task automatic run_beat(input int d, input bit r, input logic [1:0] m,
                           input logic [7:0] a, input logic [31:0] w,
                           output int lat, output logic [31:0] o,
                           output logic e, output logic b);
      @(negedge clk);
      en[d] = 1'b1; rw[d] = r; md[d] = m; ad[d] = a; din[d] = w;
      lat = -1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (moc[d]) begin lat = n; break; end
      end
      o = dout[d]; e = er[d]; b = bt[d];
      @(negedge clk);
      en[d] = 1'b0; md[d] = 2'b00; ad[d] = 8'h99; rw[d] = ~r;
      @(posedge clk); #1;
      chk($sformatf("u%0d moc_clear", d), 32'(moc[d]), 32'd0);
   endtask

   int          lat;
   logic [31:0] o;
   logic        e, b;
   int          hi;

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; en[d] = 1'b0; rw[d] = 1'b0; md[d] = 2'b00;
         ad[d] = 8'h00; din[d] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("u%0d reset outs", d), {dout[d][28:0], moc[d], bt[d], er[d]}, 32'd0);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;

      // d, rw, mode, addr, wdata, latency, check-dout, dout, err
      tbl.push_back('{0, 1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0,        1'b0});
      tbl.push_back('{0, 1'b1, 2'b00, 8'h11, 32'h0,        2, 1'b1, 32'h000000AD, 1'b0});
      tbl.push_back('{0, 1'b1, 2'b01, 8'h12, 32'h0,        2, 1'b1, 32'h0000BEEF, 1'b0});
      tbl.push_back('{0, 1'b0, 2'b10, 8'hFE, 32'hAABBCCDD, 2, 1'b1, 32'h0000BEEF, 1'b0});
      tbl.push_back('{0, 1'b1, 2'b00, 8'h00, 32'h0,        2, 1'b1, 32'h000000CC, 1'b0});
      tbl.push_back('{0, 1'b1, 2'b00, 8'hFF, 32'h0,        2, 1'b1, 32'h000000BB, 1'b0});
      tbl.push_back('{0, 1'b1, 2'b10, 8'hFE, 32'h0,        2, 1'b1, 32'hAABBCCDD, 1'b0});
      tbl.push_back('{0, 1'b1, 2'b01, 8'hFF, 32'h0,        2, 1'b1, 32'h0000BBCC, 1'b0});
      tbl.push_back('{0, 1'b0, 2'b00, 8'h40, 32'hFFFFFF5A, 2, 1'b0, 32'h0,        1'b0});
      tbl.push_back('{0, 1'b1, 2'b10, 8'h40, 32'h0,        2, 1'b0, 32'h0,        1'b0});
      tbl.push_back('{0, 1'b1, 2'b00, 8'h40, 32'h0,        2, 1'b1, 32'h0000005A, 1'b0});
      tbl.push_back('{1, 1'b0, 2'b10, 8'h04, 32'h11223344, 4, 1'b0, 32'h0,        1'b0});
      tbl.push_back('{1, 1'b0, 2'b10, 8'h08, 32'h55667788, 4, 1'b0, 32'h0,        1'b0});
      tbl.push_back('{1, 1'b0, 2'b10, 8'h05, 32'hFFFFFFFF, 4, 1'b1, 32'h0,        1'b1});
      tbl.push_back('{1, 1'b1, 2'b10, 8'h04, 32'h0,        4, 1'b1, 32'h11223344, 1'b0});
      tbl.push_back('{1, 1'b1, 2'b10, 8'h08, 32'h0,        4, 1'b1, 32'h55667788, 1'b0});
      tbl.push_back('{1, 1'b1, 2'b01, 8'h03, 32'h0,        4, 1'b1, 32'h55667788, 1'b1});
      tbl.push_back('{1, 1'b1, 2'b00, 8'h07, 32'h0,        4, 1'b1, 32'h00000044, 1'b0});
      tbl.push_back('{1, 1'b1, 2'b01, 8'h06, 32'h0,        4, 1'b1, 32'h00003344, 1'b0});

      foreach (tbl[i]) begin
         run_beat(tbl[i].d, tbl[i].rdwr, tbl[i].mode, tbl[i].addr, tbl[i].wdata, lat, o, e, b);
         chk($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].lat));
         chk($sformatf("v%0d err", i), 32'(e), 32'(tbl[i].xerr));
         if (tbl[i].cd) chk($sformatf("v%0d dout", i), o, tbl[i].xdout);
      end

      // Doubleword write then read at 0x20; beat-1 address inputs are junk.
      run_beat(0, 1'b0, 2'b11, 8'h20, 32'h01234567, lat, o, e, b);
      chk("dw wr b0 beat", 32'(b), 32'd0);
      chk("dw gap beat", 32'(bt[0]), 32'd1);
      run_beat(0, 1'b1, 2'b00, 8'h99, 32'h89ABCDEF, lat, o, e, b);
      chk("dw wr b1 beat", 32'(b), 32'd1);
      chk("dw wr b1 lat", 32'(lat), 32'd2);
      run_beat(0, 1'b1, 2'b11, 8'h20, 32'h0, lat, o, e, b);
      chk("dw rd b0 data", o, 32'h01234567);
      chk("dw rd b0 beat", 32'(b), 32'd0);
      run_beat(0, 1'b0, 2'b00, 8'h55, 32'h0, lat, o, e, b);
      chk("dw rd b1 data", o, 32'h89ABCDEF);
      chk("dw rd b1 beat", 32'(b), 32'd1);
      run_beat(0, 1'b1, 2'b00, 8'h27, 32'h0, lat, o, e, b);
      chk("M[27]", o, 32'h000000EF);

      // Misaligned doubleword: Err, no second beat, next request is fresh.
      run_beat(1, 1'b0, 2'b11, 8'h04, 32'hA5A5A5A5, lat, o, e, b);
      chk("dw misalign err", 32'(e), 32'd1);
      run_beat(1, 1'b1, 2'b10, 8'h08, 32'h0, lat, o, e, b);
      chk("after dw misalign data", o, 32'h55667788);
      chk("after dw misalign beat", 32'(b), 32'd0);

      // Enable dropped right after acceptance: single-cycle MOC pulse.
      @(negedge clk);
      en[0] = 1'b1; rw[0] = 1'b1; md[0] = 2'b10; ad[0] = 8'h10;
      @(negedge clk);
      en[0] = 1'b0;
      hi = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         if (moc[0]) hi++;
      end
      chk("early drop pulse", 32'(hi), 32'd1);
      chk("early drop data", dout[0], 32'hDEADBEEF);

      // Reset and Enable together: reset wins, nothing is accepted.
      @(negedge clk);
      rst[0] = 1'b1; en[0] = 1'b1; rw[0] = 1'b1; md[0] = 2'b00; ad[0] = 8'h11;
      @(negedge clk);
      rst[0] = 1'b0; en[0] = 1'b0;
      hi = 0;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         if (moc[0]) hi++;
      end
      chk("reset wins moc", 32'(hi), 32'd0);
      chk("reset wins dout", dout[0], 32'd0);

      // Reset during WAIT abandons a pending write.
      run_beat(1, 1'b0, 2'b10, 8'h30, 32'hCAFEF00D, lat, o, e, b);
      run_beat(1, 1'b1, 2'b10, 8'h30, 32'h0, lat, o, e, b);
      chk("pre-reset read", o, 32'hCAFEF00D);
      @(negedge clk);
      en[1] = 1'b1; rw[1] = 1'b0; md[1] = 2'b10; ad[1] = 8'h30; din[1] = 32'h99999999;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst[1] = 1'b1; en[1] = 1'b0;
      @(posedge clk); #1;
      chk("mid reset outs", {dout[1][29:0], moc[1], bt[1]}, 32'd0);
      @(negedge clk);
      rst[1] = 1'b0;
      run_beat(1, 1'b1, 2'b10, 8'h30, 32'h0, lat, o, e, b);
      chk("write abandoned", o, 32'hCAFEF00D);

      // Zero wait states: load M[i]=i, then read every byte back.
      for (int i = 0; i < 256; i++) begin
         run_beat(2, 1'b0, 2'b00, 8'(i), {24'hFFFFFF, 8'(i)}, lat, o, e, b);
         chk($sformatf("ld%0d lat", i), 32'(lat), 32'd1);
      end
      for (int i = 0; i < 256; i++) begin
         run_beat(2, 1'b1, 2'b00, 8'(i), 32'h0, lat, o, e, b);
         chk($sformatf("rd%0d lat", i), 32'(lat), 32'd1);
         chk($sformatf("rd%0d data", i), o, 32'(i));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
